uart_rx_param: RTL and testbench

- Parametrised UART receiver: next generation of the fixed 8-data/even-parity/1-stop, 14-clocks-per-bit receiver on clk_3125.
- Adds configurable data width, parity mode, stop bits, bit order and oversampling ratio.
- Adds mid-bit sampling, false-start rejection, framing and overrun detection, and a valid/ready output handshake.
- Sits between the board RX pin and the message-handling logic.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_rx_param.sv | 157 +++++++++++++++
 tb/tb_uart_rx_param.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [7:0] ERR_CHAR = 8'h3F;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: half_tick at mid start bit, full_tick once per bit period.
// Latency: strobes are combinational from cnt; restart zeroes cnt on the next edge.
// Backpressure: none; free-running while restart is low.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 14
) (
    input  logic clk_3125,
    input  logic rst,
    input  logic restart,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL    = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_3125) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == FULL) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign half_tick = (cnt == HALF_M1);
    assign full_tick = (cnt == FULL);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with mid-bit sampling and a valid/ready output; UART_RX_ERR_SUBST_EN swaps errored words for '?'.
// Latency: rx_valid/rx_complete rise the cycle after the last stop sample (plus 2-flop synchroniser on rx).
// Backpressure: one output slot; a frame completing while rx_valid && !rx_ready is dropped and sets sticky overrun_err.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 14,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic                 clk_3125,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_msg,
    output logic                 rx_parity,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_complete,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam parity_mode_t PMODE = parity_mode_t'(PARITY_MODE[1:0]);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
`ifdef UART_RX_ERR_SUBST_EN
    localparam logic [DATA_BITS-1:0] ERR_WORD = DATA_BITS'(ERR_CHAR);
`endif

    rx_state_t            state, state_nxt;
    logic                 rx_meta, rx_s;
    logic                 half_tick, full_tick, restart;
    logic                 data_smp, par_smp, stop_smp, last_data, frame_done;
    logic [BW-1:0]        bitn;
    logic [DATA_BITS-1:0] shreg, msg_in;
    logic                 par_bit, ferr_acc, armed;
    logic                 perr_now, ferr_now, data_par;

    always_ff @(posedge clk_3125) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk_3125  (clk_3125),
        .rst       (rst),
        .restart   (restart),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clk_3125) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // armed blocks re-triggering while a break holds the line low
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!rx_s && armed) state_nxt = START;
            START:   if (half_tick) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (last_data) state_nxt = (PMODE != PAR_NONE) ? PARITY : STOP;
            PARITY:  if (par_smp) state_nxt = STOP;
            STOP:    if (frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        restart  = 1'b0;
        data_smp = 1'b0;
        par_smp  = 1'b0;
        stop_smp = 1'b0;
        case (state)
            IDLE:    restart  = 1'b1;
            START:   restart  = half_tick;
            DATA:    data_smp = full_tick;
            PARITY:  par_smp  = full_tick;
            STOP:    stop_smp = full_tick;
            default: restart  = 1'b1;
        endcase
        last_data  = data_smp && (bitn == LAST_DATA);
        frame_done = stop_smp && (bitn == LAST_STOP);
    end

    always_comb begin
        data_par = (^shreg) ^ par_bit;
        perr_now = 1'b0;
        if (PMODE == PAR_EVEN) perr_now = data_par;
        if (PMODE == PAR_ODD)  perr_now = ~data_par;
        ferr_now = ferr_acc | ~rx_s;
`ifdef UART_RX_ERR_SUBST_EN
        msg_in = (perr_now || ferr_now) ? ERR_WORD : shreg;
`else
        msg_in = shreg;
`endif
    end

    always_ff @(posedge clk_3125) begin
        if (rst) begin
            bitn        <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            ferr_acc    <= 1'b0;
            armed       <= 1'b0;
            rx_msg      <= '0;
            rx_parity   <= 1'b0;
            rx_valid    <= 1'b0;
            rx_complete <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_complete <= frame_done;
            if (state == START) begin
                bitn     <= '0;
                par_bit  <= 1'b0;
                ferr_acc <= 1'b0;
            end
            if (data_smp) begin
                if (MSB_FIRST != 0) shreg <= {shreg[DATA_BITS-2:0], rx_s};
                else                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                bitn <= last_data ? '0 : bitn + 1'b1;
            end
            if (par_smp) par_bit <= rx_s;
            if (stop_smp) begin
                if (!rx_s) ferr_acc <= 1'b1;
                bitn <= frame_done ? '0 : bitn + 1'b1;
            end

            if (rx_s)                    armed <= 1'b1;
            else if (frame_done)         armed <= 1'b0;

            if (frame_done && (!rx_valid || rx_ready)) begin
                rx_msg     <= msg_in;
                rx_parity  <= par_bit;
                parity_err <= perr_now;
                frame_err  <= ferr_now;
                rx_valid   <= 1'b1;
            end else begin
                if (frame_done) overrun_err <= 1'b1;
                if (rx_valid && rx_ready) rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: default 8E1 MSB-first instance plus a 7O2 LSB-first, 16x instance.
module tb_uart_rx_param;

    logic clk_3125 = 1'b0;
    always #5 clk_3125 = ~clk_3125;

    logic       rst_a, rx_a, rdy_a;
    logic [7:0] msg_a;
    logic       par_a, vld_a, cmp_a, perr_a, ferr_a, ovr_a;

    logic       rst_b, rx_b, rdy_b;
    logic [6:0] msg_b;
    logic       par_b, vld_b, cmp_b, perr_b, ferr_b, ovr_b;

    uart_rx_param u_dut_a (
        .clk_3125    (clk_3125),
        .rst         (rst_a),
        .rx          (rx_a),
        .rx_msg      (msg_a),
        .rx_parity   (par_a),
        .rx_valid    (vld_a),
        .rx_ready    (rdy_a),
        .rx_complete (cmp_a),
        .parity_err  (perr_a),
        .frame_err   (ferr_a),
        .overrun_err (ovr_a)
    );

    uart_rx_param #(
        .CLKS_PER_BIT (16),
        .DATA_BITS    (7),
        .PARITY_MODE  (2),
        .STOP_BITS    (2),
        .MSB_FIRST    (0)
    ) u_dut_b (
        .clk_3125    (clk_3125),
        .rst         (rst_b),
        .rx          (rx_b),
        .rx_msg      (msg_b),
        .rx_parity   (par_b),
        .rx_valid    (vld_b),
        .rx_ready    (rdy_b),
        .rx_complete (cmp_b),
        .parity_err  (perr_b),
        .frame_err   (ferr_b),
        .overrun_err (ovr_b)
    );

`ifdef UART_RX_ERR_SUBST_EN
    localparam logic [7:0] PERR_MSG_41 = 8'h3F;
    localparam logic [7:0] FERR_MSG_55 = 8'h3F;
`else
    localparam logic [7:0] PERR_MSG_41 = 8'h41;
    localparam logic [7:0] FERR_MSG_55 = 8'h55;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    int         cmp_cnt_a = 0, cmp_cnt_b = 0, acc_cnt_a = 0;
    logic [7:0] acc_msg  = '0;
    logic       acc_par  = 1'b0, acc_perr = 1'b0, acc_ferr = 1'b0;

    always @(negedge clk_3125) begin
        if (cmp_a) cmp_cnt_a++;
        if (cmp_b) cmp_cnt_b++;
        if (vld_a && rdy_a) begin
            acc_cnt_a++;
            acc_msg  = msg_a;
            acc_par  = par_a;
            acc_perr = perr_a;
            acc_ferr = ferr_a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_3125);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic p, input logic s);
        rx_a = 1'b0; wait_cyc(14);
        for (int i = 7; i >= 0; i--) begin
            rx_a = d[i]; wait_cyc(14);
        end
        rx_a = p; wait_cyc(14);
        rx_a = s; wait_cyc(14);
        rx_a = 1'b1;
    endtask

    task automatic send_b(input logic [6:0] d, input logic p);
        rx_b = 1'b0; wait_cyc(16);
        for (int i = 0; i < 7; i++) begin
            rx_b = d[i]; wait_cyc(16);
        end
        rx_b = p;    wait_cyc(16);
        rx_b = 1'b1; wait_cyc(32);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        rx_a  = 1'b1; rx_b  = 1'b1;
        rdy_a = 1'b1; rdy_b = 1'b0;
        wait_cyc(3);
        chk("rst_msg_a", 32'(msg_a), 32'h0);
        chk("rst_flags_a", 32'({par_a, vld_a, cmp_a, perr_a, ferr_a, ovr_a}), 32'h0);
        chk("rst_flags_b", 32'({msg_b, par_b, vld_b, cmp_b, perr_b, ferr_b, ovr_b}), 32'h0);
        rst_a = 1'b0; rst_b = 1'b0;
        wait_cyc(5);

        // clean 8'h41, even parity bit 0
        send_a(8'h41, 1'b0, 1'b1); wait_cyc(3);
        chk("f41_complete", 32'(cmp_cnt_a), 32'd1);
        chk("f41_accepted", 32'(acc_cnt_a), 32'd1);
        chk("f41_msg", 32'(acc_msg), 32'h41);
        chk("f41_flags", 32'({acc_par, acc_perr, acc_ferr}), 32'h0);
        chk("f41_vld_drop", 32'(vld_a), 32'h0);

        // same word, parity bit flipped
        send_a(8'h41, 1'b1, 1'b1); wait_cyc(3);
        chk("perr_msg", 32'(acc_msg), 32'(PERR_MSG_41));
        chk("perr_flags", 32'({acc_par, acc_perr, acc_ferr}), 32'b110);
        chk("perr_complete", 32'(cmp_cnt_a), 32'd2);

        // 5-cycle glitch must be rejected, then 8'hA5 received
        rx_a = 1'b0; wait_cyc(5); rx_a = 1'b1; wait_cyc(40);
        chk("glitch_no_frame", 32'(cmp_cnt_a), 32'd2);
        send_a(8'hA5, 1'b0, 1'b1); wait_cyc(3);
        chk("a5_msg", 32'(acc_msg), 32'hA5);
        chk("a5_flags", 32'({acc_perr, acc_ferr}), 32'h0);
        chk("a5_complete", 32'(cmp_cnt_a), 32'd3);

        // overrun: second frame dropped while first waits
        rdy_a = 1'b0;
        send_a(8'h11, 1'b0, 1'b1);
        send_a(8'h22, 1'b0, 1'b1); wait_cyc(3);
        chk("ovr_vld", 32'(vld_a), 32'h1);
        chk("ovr_msg_held", 32'(msg_a), 32'h11);
        chk("ovr_flag", 32'(ovr_a), 32'h1);
        chk("ovr_complete", 32'(cmp_cnt_a), 32'd5);
        rdy_a = 1'b1; wait_cyc(1); rdy_a = 1'b0;
        chk("ovr_vld_drop", 32'(vld_a), 32'h0);
        chk("ovr_acc_msg", 32'(acc_msg), 32'h11);
        chk("ovr_acc_cnt", 32'(acc_cnt_a), 32'd4);

        // stop bit 0 then line held low (break) for 3 frame times
        rdy_a = 1'b1;
        send_a(8'h55, 1'b0, 1'b0);
        rx_a = 1'b0; wait_cyc(3 * 154);
        rx_a = 1'b1; wait_cyc(30);
        chk("brk_one_frame", 32'(cmp_cnt_a), 32'd6);
        chk("brk_msg", 32'(acc_msg), 32'(FERR_MSG_55));
        chk("brk_flags", 32'({acc_perr, acc_ferr}), 32'b01);
        chk("brk_ovr_sticky", 32'(ovr_a), 32'h1);

        // 7-bit odd parity, LSB first, 2 stop bits: 7'h5A has four ones -> parity 1
        send_b(7'h5A, 1'b1); wait_cyc(3);
        chk("b_vld", 32'(vld_b), 32'h1);
        chk("b_msg", 32'(msg_b), 32'h5A);
        chk("b_flags", 32'({par_b, perr_b, ferr_b, ovr_b}), 32'b1000);
        chk("b_complete", 32'(cmp_cnt_b), 32'd1);

        // reset partway through the next frame
        rx_b = 1'b0; wait_cyc(16);
        rx_b = 1'b1; wait_cyc(16);
        rx_b = 1'b0; wait_cyc(8);
        rst_b = 1'b1; wait_cyc(2);
        chk("b_rst_out", 32'({msg_b, par_b, vld_b, cmp_b, perr_b, ferr_b, ovr_b}), 32'h0);
        rx_b = 1'b1; rst_b = 1'b0;
        wait_cyc(200);
        chk("b_rst_no_frame", 32'(cmp_cnt_b), 32'd1);
        chk("b_rst_idle_out", 32'({msg_b, vld_b}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
